// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC NCO source: FSM encoding and
// helpers for the gain-compensation constant and pipeline latency.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Inverse CORDIC gain 0.607252935 scaled by 2**(w-1), rounded to nearest.
    // Integer arithmetic (scaled by 1e9) keeps this usable as a constant.
    function automatic int kinv(input int w);
        longint unsigned t;
        t = (64'd607252935 << (w - 1)) + 64'd500000000;
        return int'(t / 64'd1000000000);
    endfunction

    // Input-to-output register count of the pipelined rotation CORDIC.
    function automatic int cordic_latency(input int iterations);
        return iterations + 1;
    endfunction

endpackage

// File: rtl/cordic_nco_source_valid_delay.sv
// One-bit valid shift register matched to the CORDIC pipeline depth.
// any_o reports whether any valid will still be inside the line after
// the coming edge, so the owner can finish exactly when the last valid
// leaves the output.
module valid_delay #(
    parameter int depth = 18
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic in_i,
    output logic out_o,
    output logic any_o
);

    logic [depth-1:0] sr_q;
    logic [depth-1:0] sr_d;

    assign sr_d  = {sr_q[depth-2:0], in_i};
    assign out_o = sr_q[depth-1];
    assign any_o = |sr_d;

    // Shift one stage per cycle; synchronous clear empties the whole line.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/cordic_nco_source.sv
// NCO front end for the polar-rotation CORDIC: phase accumulator drives z0,
// gain-precompensated amplitude drives x0, y0 is tied to zero. Bursts are
// started/stopped by pulses, and a valid flag is carried alongside the
// CORDIC pipeline so out_valid lines up with the CORDIC results.
module cordic_nco_source
    import cordic_pkg::*;
#(
    parameter int width      = 16,
    parameter int acc_width  = 32,
    parameter int iterations = width + 1,
    parameter int latency    = cordic_latency(iterations),
    parameter int cnt_width  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [cnt_width-1:0] burst_len,
    input  logic                 freq_we,
    input  logic [acc_width-1:0] freq_word,
    input  logic                 phase_we,
    input  logic [width-1:0]     phase_off,
    input  logic                 amp_we,
    input  logic [width-1:0]     amp,
    output logic [width-1:0]     x0,
    output logic [width-1:0]     y0,
    output logic [width-1:0]     z0,
    output logic                 src_valid,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic signed [width-1:0]   KINV = width'(kinv(width));
    localparam logic signed [2*width-1:0] RND  = (2*width)'(1) << (width - 2);

    state_e               state_q, state_d;
    logic [acc_width-1:0] acc_q, acc_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [acc_width-1:0] freq_q, freq_d;
    logic [width-1:0]     phase_off_q, phase_off_d;
    logic [width-1:0]     amp_q, amp_d;
    logic [width-1:0]     x0_q, x0_d;
    logic [width-1:0]     z0_q, z0_d;
    logic                 src_valid_q, src_valid_d;
    logic                 done_q, done_d;

    logic signed [2*width-1:0] prod_w;
    logic                      line_any;

    assign prod_w = $signed(amp_q) * KINV;

    // Next-state logic: config capture, burst FSM and sample generation.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        freq_d      = freq_we  ? freq_word : freq_q;
        phase_off_d = phase_we ? phase_off : phase_off_q;
        amp_d       = amp_we   ? amp       : amp_q;
        x0_d        = x0_q;
        z0_d        = z0_q;
        src_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // stop has priority over a simultaneous start
                if (start && !stop) begin
                    state_d = RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else begin
                    z0_d        = acc_q[acc_width-1 -: width] + phase_off_q;
                    x0_d        = width'((prod_w + RND) >>> (width - 1));
                    acc_d       = acc_q + freq_q;
                    cnt_d       = cnt_q + cnt_width'(1);
                    src_valid_d = 1'b1;
                    // burst_len of zero means run until stopped
                    if ((burst_len != '0) && (cnt_q == burst_len - cnt_width'(1))) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // leave as the last in-flight valid emerges; done lands the cycle after
                if (!line_any) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            freq_q      <= '0;
            phase_off_q <= '0;
            amp_q       <= '0;
            x0_q        <= '0;
            z0_q        <= '0;
            src_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            freq_q      <= freq_d;
            phase_off_q <= phase_off_d;
            amp_q       <= amp_d;
            x0_q        <= x0_d;
            z0_q        <= z0_d;
            src_valid_q <= src_valid_d;
            done_q      <= done_d;
        end
    end

    valid_delay #(
        .depth (latency)
    ) u_valid_delay (
        .clk_i (clk),
        .clr_i (reset),
        .in_i  (src_valid_q),
        .out_o (out_valid),
        .any_o (line_any)
    );

    assign x0        = x0_q;
    assign y0        = '0;
    assign z0        = z0_q;
    assign src_valid = src_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
